// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin req/ack arbiter sharing one add/sub unit.
// Optional: define SIGNED_OVF_EN to add the res_ovf signed-overflow output.
module addsub_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         op0,
    output logic         ack0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         op1,
    output logic         ack1,
    output logic [W-1:0] as_a,
    output logic [W-1:0] as_b,
    output logic         as_s,
    input  logic         as_cob,
    input  logic [W-1:0] as_out,
    output logic [W-1:0] res,
    output logic         res_cob,
    output logic         res_id,
`ifdef SIGNED_OVF_EN
    output logic         res_ovf,
`endif
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic       last;
    logic       gid;
    logic       gnt_v;
    logic       gnt;

    // winner selection: single requester wins, ties go to the one not served last
    always_comb begin
        gnt_v = req0 | req1;
        gnt   = (req0 && req1) ? ~last : req1;
    end

`ifdef SIGNED_OVF_EN
    logic ovf;

    // signed overflow of the latched operands as seen by the shared unit
    always_comb begin
        ovf = ((as_a[W-1] ^ as_b[W-1]) == as_s) &&
              (as_out[W-1] != as_a[W-1]);
    end
`endif

    // FSM: grant in IDLE, settle and capture in EXEC, ack pulse in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            gid     <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            as_a    <= '0;
            as_b    <= '0;
            as_s    <= 1'b0;
            res     <= '0;
            res_cob <= 1'b0;
            res_id  <= 1'b0;
            busy    <= 1'b0;
`ifdef SIGNED_OVF_EN
            res_ovf <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (gnt_v) begin
                        as_a  <= gnt ? a1 : a0;
                        as_b  <= gnt ? b1 : b0;
                        as_s  <= gnt ? op1 : op0;
                        gid   <= gnt;
                        last  <= gnt;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res     <= as_out;
                    res_cob <= as_cob;
                    res_id  <= gid;
`ifdef SIGNED_OVF_EN
                    res_ovf <= ovf;
`endif
                    ack0    <= ~gid;
                    ack1    <= gid;
                    state   <= DONE;
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed tests for addsub_arbiter.
// Models the shared add/sub unit combinationally on the as_* ports.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic [7:0] a0 = '0;
    logic [7:0] b0 = '0;
    logic       op0 = 1'b0;
    logic       ack0;
    logic       req1 = 1'b0;
    logic [7:0] a1 = '0;
    logic [7:0] b1 = '0;
    logic       op1 = 1'b0;
    logic       ack1;
    logic [7:0] as_a;
    logic [7:0] as_b;
    logic       as_s;
    logic       as_cob;
    logic [7:0] as_out;
    logic [7:0] res;
    logic       res_cob;
    logic       res_id;
    logic       busy;
`ifdef SIGNED_OVF_EN
    logic       res_ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // shared add/sub unit
    assign {as_cob, as_out} = as_s ?
        ({1'b0, as_a} - {1'b0, as_b}) :
        ({1'b0, as_a} + {1'b0, as_b});

    addsub_arbiter #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .ack1(ack1),
        .as_a(as_a), .as_b(as_b), .as_s(as_s),
        .as_cob(as_cob), .as_out(as_out),
        .res(res), .res_cob(res_cob), .res_id(res_id),
`ifdef SIGNED_OVF_EN
        .res_ovf(res_ovf),
`endif
        .busy(busy)
    );

    // one transaction from one requester; returns what was observed
    task automatic run_op(
        input  bit       id,
        input  bit [7:0] a,
        input  bit [7:0] b,
        input  bit       op,
        output bit [7:0] r,
        output bit       cob,
        output bit       rid,
        output int       lat,
        output int       bc,
        output bit       wrong
    );
        bit got;
        int n;
        got = 0; n = 0; lat = -1; bc = 0; wrong = 0;
        r = '0; cob = 0; rid = 0;
        @(negedge clk);
        if (id) begin
            a1 = a; b1 = b; op1 = op; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; op0 = op; req0 = 1'b1;
        end
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (ack0 && ack1) wrong = 1;
            if (id ? ack0 : ack1) wrong = 1;
            if (id ? ack1 : ack0) begin
                got = 1; lat = n;
                r = res; cob = res_cob; rid = res_id;
            end
        end
        if (id) req1 = 1'b0;
        else req0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit [7:0] r; bit cob, rid, wr; int lat, bc;
        do_reset();
        total++;
        if ({ack0, ack1, as_a, as_b, as_s, res, res_cob, res_id, busy}
            !== '0) begin
            bad++;
            $display("FAIL reset_outputs got res=%h busy=%b as_a=%h want 0",
                     res, busy, as_a);
        end
        run_op(0, 8'h05, 8'h03, 0, r, cob, rid, lat, bc, wr);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL first_latency got %0d want 2", lat);
        end
        total++;
        if (bc !== 2) begin
            bad++;
            $display("FAIL first_busy got %0d want 2", bc);
        end
        total++;
        if ({r, cob, rid, wr} !== {8'h08, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL first_result got %h/%b/%b/%b want 08/0/0/0",
                     r, cob, rid, wr);
        end
    endtask

    task automatic test_arith();
        bit [7:0] r; bit cob, rid, wr; int lat, bc;
        run_op(1, 8'hFF, 8'h01, 0, r, cob, rid, lat, bc, wr);
        total++;
        if ({r, cob, rid, wr} !== {8'h00, 1'b1, 1'b1, 1'b0} || lat != 2) begin
            bad++;
            $display("FAIL add_carry got %h/%b/%b/%b lat=%0d want 00/1/1/0 2",
                     r, cob, rid, wr, lat);
        end
        run_op(1, 8'h03, 8'h05, 1, r, cob, rid, lat, bc, wr);
        total++;
        if ({r, cob, rid, wr} !== {8'hFE, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_borrow got %h/%b/%b/%b want fe/1/1/0",
                     r, cob, rid, wr);
        end
        run_op(1, 8'h05, 8'h03, 1, r, cob, rid, lat, bc, wr);
        total++;
        if ({r, cob, rid, wr} !== {8'h02, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_plain got %h/%b/%b/%b want 02/0/1/0",
                     r, cob, rid, wr);
        end
        run_op(0, 8'hA0, 8'h70, 0, r, cob, rid, lat, bc, wr);
        total++;
        if ({r, cob, rid, wr} !== {8'h10, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL add_req0 got %h/%b/%b/%b want 10/1/0/0",
                     r, cob, rid, wr);
        end
    endtask

    task automatic test_round_robin();
        bit [3:0] order;
        int k, n;
        bit both;
        k = 0; n = 0; both = 0; order = '0;
        @(negedge clk);
        rst = 1'b1;
        a0 = 8'h11; b0 = 8'h22; op0 = 0; req0 = 1'b1;
        a1 = 8'h50; b1 = 8'h60; op1 = 1; req1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        while (k < 4 && n < 30) begin
            @(negedge clk);
            n++;
            if (ack0 && ack1) both = 1;
            if (ack0 || ack1) begin
                order[k] = ack1;
                total++;
                if (ack1 ? ({res, res_cob, res_id} !== {8'hF0, 1'b1, 1'b1})
                         : ({res, res_cob, res_id} !== {8'h33, 1'b0, 1'b0})) begin
                    bad++;
                    $display("FAIL rr_result[%0d] got %h/%b/%b ack1=%b",
                             k, res, res_cob, res_id, ack1);
                end
                k++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (k !== 4 || order !== 4'b1010) begin
            bad++;
            $display("FAIL rr_order got n=%0d order=%b want 4 1010", k, order);
        end
        total++;
        if (both) begin
            bad++;
            $display("FAIL rr_dual_ack got both acks high want never");
        end
    endtask

    task automatic test_reset_mid();
        bit [7:0] r; bit cob, rid, wr; int lat, bc;
        bit seen;
        seen = 0;
        @(negedge clk);
        @(negedge clk);
        a0 = 8'h44; b0 = 8'h11; op0 = 0; req0 = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_exec got busy=%b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ack0, ack1, as_a, as_b, as_s, res, res_cob, res_id, busy}
            !== '0) begin
            bad++;
            $display("FAIL mid_reset got as_a=%h res=%h busy=%b want 0",
                     as_a, res, busy);
        end
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack0 || ack1) seen = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack0 || ack1) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mid_no_ack got ack after reset want none");
        end
        run_op(1, 8'h10, 8'h20, 0, r, cob, rid, lat, bc, wr);
        total++;
        if ({r, cob, rid, wr} !== {8'h30, 1'b0, 1'b1, 1'b0} || lat != 2) begin
            bad++;
            $display("FAIL post_reset got %h/%b/%b/%b lat=%0d want 30/0/1/0 2",
                     r, cob, rid, wr, lat);
        end
    endtask

    task automatic test_withdraw();
        bit extra;
        extra = 0;
        @(negedge clk);
        @(negedge clk);
        a0 = 8'h21; b0 = 8'h09; op0 = 1; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        total++;
        if ({ack0, ack1, res, res_cob, res_id} !==
            {1'b1, 1'b0, 8'h18, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL withdraw_ack got ack=%b%b res=%h/%b/%b want 10 18/0/0",
                     ack0, ack1, res, res_cob, res_id);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) extra = 1;
        end
        total++;
        if (extra) begin
            bad++;
            $display("FAIL withdraw_idle got activity want idle");
        end
        total++;
        if ({as_a, as_b, as_s} !== {8'h21, 8'h09, 1'b1}) begin
            bad++;
            $display("FAIL idle_hold got %h/%h/%b want 21/09/1",
                     as_a, as_b, as_s);
        end
    endtask

`ifdef SIGNED_OVF_EN
    task automatic test_ovf();
        bit [7:0] r; bit cob, rid, wr; int lat, bc;
        run_op(0, 8'h7F, 8'h01, 0, r, cob, rid, lat, bc, wr);
        total++;
        if (r !== 8'h80 || res_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_add got %h/%b want 80/1", r, res_ovf);
        end
        run_op(0, 8'h80, 8'h01, 1, r, cob, rid, lat, bc, wr);
        total++;
        if (r !== 8'h7F || res_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sub got %h/%b want 7f/1", r, res_ovf);
        end
        run_op(1, 8'h10, 8'h10, 0, r, cob, rid, lat, bc, wr);
        total++;
        if (r !== 8'h20 || res_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_none got %h/%b want 20/0", r, res_ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_round_robin();
        test_reset_mid();
        test_withdraw();
`ifdef SIGNED_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
